// File: rtl/word_demux_pkg.sv
// -----------------------------------------------------------------------------
// word_demux_pkg
// Shared types and defaults for the word_demux_loader block.
//   wdl_state_t    : load FSM state encoding (IDLE / LOAD / FULL)
//   DEFAULT_WIDTH  : default word width in bits
//   DEFAULT_DEPTH  : default number of bank slots
// Optional feature macro used by the top: WORD_DEMUX_BYPASS_EN
// -----------------------------------------------------------------------------
package word_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } wdl_state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 64;

endpackage : word_demux_pkg

// File: rtl/word_slot_reg.sv
// -----------------------------------------------------------------------------
// word_slot_reg
// One bank slot: a WIDTH-bit register with load enable and a synchronous
// active-low clear. The clear has priority over the enable.
// Ports:
//   clk      in   1      clock
//   clr_n_i  in   1      synchronous clear, active-low
//   en_i     in   1      load d_i at the next rising edge
//   d_i      in   WIDTH  data to store
//   q_o      out  WIDTH  stored word
// -----------------------------------------------------------------------------
module word_slot_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Slot storage: clear wins over load
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            data_q <= {WIDTH{1'b0}};
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : word_slot_reg

// File: rtl/word_demux_loader.sv
// -----------------------------------------------------------------------------
// word_demux_loader
// Accepts a serial stream of WIDTH-bit words over valid/ready and writes them,
// in arrival order, into a DEPTH-entry register bank. A random-access read port
// exposes any slot while the bank fills.
// Ports:
//   clk       in   1       clock, rising edge
//   reset_n   in   1       synchronous active-low reset (clears FSM, count, bank)
//   start     in   1       begin a new load (count back to 0, state LOAD)
//   in_valid  in   1       in_data holds a word
//   in_data   in   WIDTH   input word
//   in_ready  out  1       word will be accepted this cycle (state LOAD)
//   rd_idx    in   CNTW    read slot select
//   rd_data   out  WIDTH   contents of slot rd_idx (combinational)
//   wr_count  out  CNTW+1  words written in the current load (0..DEPTH)
//   busy      out  1       state is LOAD
//   full      out  1       state is FULL
// Configuration macro: WORD_DEMUX_BYPASS_EN
//   defined     -> a word being written to the slot selected by rd_idx is
//                  forwarded to rd_data in the same cycle
//   not defined -> rd_data shows registered bank contents only
// -----------------------------------------------------------------------------
module word_demux_loader
    import word_demux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CNTW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [CNTW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNTW:0]    wr_count,
    output logic             busy,
    output logic             full
);

    localparam logic [CNTW:0] LAST_IDX = (CNTW+1)'(DEPTH - 1);
    localparam logic [CNTW:0] CNT_ONE  = (CNTW+1)'(1);

    wdl_state_t       state_q;
    wdl_state_t       state_d;
    logic [CNTW:0]    cnt_q;
    logic [CNTW:0]    cnt_d;
    logic             ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] rd_data_s;

    // in_ready is a pure function of state, so it never depends on in_valid
    assign ready_s = (state_q == LOAD);

    // start takes precedence: a word offered alongside start is dropped
    assign xfer_s = in_valid & ready_s & ~start;

    // State and write-count registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= {(CNTW+1){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = LOAD;
            cnt_d   = {(CNTW+1){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LOAD: begin
                    if (xfer_s) begin
                        cnt_d = cnt_q + CNT_ONE;
                        // The last slot is written on this edge; count lands on DEPTH
                        if (cnt_q == LAST_IDX) begin
                            state_d = FULL;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {(CNTW+1){1'b0}};
                end
            endcase
        end
    end

    // Bank: one slot register per index, loaded when the write counter points at it
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic en_s;
        assign en_s = xfer_s & (cnt_q == (CNTW+1)'(i));

        word_slot_reg #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .clr_n_i (reset_n),
            .en_i    (en_s),
            .d_i     (in_data),
            .q_o     (bank_q[i])
        );
    end

    // Read mux, with optional write-through forwarding of the word being written
    always_comb begin
        rd_data_s = bank_q[rd_idx];
`ifdef WORD_DEMUX_BYPASS_EN
        if (xfer_s && (rd_idx == cnt_q[CNTW-1:0])) begin
            rd_data_s = in_data;
        end else begin
            rd_data_s = bank_q[rd_idx];
        end
`endif
    end

    assign rd_data  = rd_data_s;
    assign in_ready = ready_s;
    assign wr_count = cnt_q;
    assign busy     = (state_q == LOAD);
    assign full     = (state_q == FULL);

endmodule : word_demux_loader

// File: tb/tb_word_demux_loader.sv
// -----------------------------------------------------------------------------
// tb_word_demux_loader
// Directed bench for word_demux_loader (WIDTH=32, DEPTH=64): a vector table of
// single-cycle records followed by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_word_demux_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int CNTW  = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = 32'h0;
    logic             in_ready;
    logic [CNTW-1:0]  rd_idx = 6'd0;
    logic [WIDTH-1:0] rd_data;
    logic [CNTW:0]    wr_count;
    logic             busy;
    logic             full;

    int checks   = 0;
    int failures = 0;

    word_demux_loader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .wr_count (wr_count),
        .busy     (busy),
        .full     (full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        st;
        logic        v;
        logic [31:0] d;
        logic [5:0]  idx;
        logic        e_ready;
        logic        e_busy;
        logic        e_full;
        logic [6:0]  e_cnt;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge
    task automatic do_cycle(input logic r, input logic s, input logic v,
                            input logic [31:0] d, input logic [5:0] idx);
        @(negedge clk);
        reset_n  = r;
        start    = s;
        in_valid = v;
        in_data  = d;
        rd_idx   = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic e_ready, input logic e_busy,
                                input logic e_full, input logic [6:0] e_cnt);
        check({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, e_ready});
        check({tag, ".busy"},     {63'd0, busy},     {63'd0, e_busy});
        check({tag, ".full"},     {63'd0, full},     {63'd0, e_full});
        check({tag, ".wr_count"}, {57'd0, wr_count}, {57'd0, e_cnt});
    endtask

    initial begin
        logic [31:0] exp_rd;

        // Each record: inputs held across one rising edge, outputs sampled after it
        vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'd0,  1'b0, 1'b0, 1'b0, 7'd0, 32'h0000_0000};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'd63, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0000_0000};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA, 6'd0,  1'b0, 1'b0, 1'b0, 7'd0, 32'h0000_0000};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 32'hBBBB_BBBB, 6'd5,  1'b1, 1'b1, 1'b0, 7'd0, 32'h0000_0000};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0011, 6'd0,  1'b1, 1'b1, 1'b0, 7'd1, 32'h0000_0011};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0022, 6'd0,  1'b1, 1'b1, 1'b0, 7'd1, 32'h0000_0011};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0033, 6'd1,  1'b1, 1'b1, 1'b0, 7'd2, 32'h0000_0033};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 6'd0,  1'b1, 1'b1, 1'b0, 7'd0, 32'h0000_0011};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 6'd1,  1'b1, 1'b1, 1'b0, 7'd0, 32'h0000_0033};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0044, 6'd0,  1'b1, 1'b1, 1'b0, 7'd1, 32'h0000_0044};
        vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'd0,  1'b0, 1'b0, 1'b0, 7'd0, 32'h0000_0000};
        vt[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 6'd1,  1'b0, 1'b0, 1'b0, 7'd0, 32'h0000_0000};

        for (int k = 0; k < 12; k++) begin
            do_cycle(vt[k].rst_n, vt[k].st, vt[k].v, vt[k].d, vt[k].idx);
            check_status($sformatf("vec%0d", k), vt[k].e_ready, vt[k].e_busy, vt[k].e_full, vt[k].e_cnt);
            check($sformatf("vec%0d.rd_data", k), {32'd0, rd_data}, {32'd0, vt[k].e_rd});
        end

        // Full load of 64 back-to-back words
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 6'd0);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 1'b0, 1'b1, 32'h1000_0000 + 32'(i), 6'd0);
            check($sformatf("load.wr_count%0d", i), {57'd0, wr_count}, 64'(i + 1));
            check($sformatf("load.full%0d", i), {63'd0, full}, {63'd0, (i == DEPTH - 1)});
        end
        do_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 6'd0);
        check_status("full_hold", 1'b0, 1'b0, 1'b1, 7'd64);
        check("full_hold.slot0", {32'd0, rd_data}, 64'h1000_0000);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            rd_idx = 6'(i);
            #1;
            check($sformatf("full.rd%0d", i), {32'd0, rd_data}, {32'd0, 32'h1000_0000 + 32'(i)});
        end

        // Backpressure: valid on even cycles only
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 6'd63);
        for (int k = 0; k < 14; k++) begin
            do_cycle(1'b1, 1'b0, (k % 2 == 0), 32'h3000_0000 + 32'(k), 6'd63);
            check($sformatf("bp.wr_count%0d", k), {57'd0, wr_count}, 64'(k / 2 + 1));
        end
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 6'd5);
        check("bp.slot5", {32'd0, rd_data}, 64'h3000_000A);
        check_status("bp_end", 1'b1, 1'b1, 1'b0, 7'd7);

        // Restart mid-load: the word offered with start is dropped
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 6'd63);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 1'b0, 1'b1, 32'h4000_0000 + 32'(i), 6'd63);
        end
        check("rs.wr_count10", {57'd0, wr_count}, 64'd10);
        do_cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 6'd63);
        check_status("rs_start", 1'b1, 1'b1, 1'b0, 7'd0);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 6'd0);
        check("rs.slot0_old", {32'd0, rd_data}, 64'h4000_0000);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 6'd10);
        check("rs.slot10_old", {32'd0, rd_data}, 64'h1000_000A);
        do_cycle(1'b1, 1'b0, 1'b1, 32'h5555_0000, 6'd1);
        check("rs.wr_count1", {57'd0, wr_count}, 64'd1);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 6'd0);
        check("rs.slot0_new", {32'd0, rd_data}, 64'h5555_0000);

        // Reset mid-load at wr_count=30 clears the bank
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 6'd63);
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'b1, 1'b0, 1'b1, 32'h6000_0000 + 32'(i), 6'd63);
        end
        check("rm.wr_count30", {57'd0, wr_count}, 64'd30);
        do_cycle(1'b0, 1'b0, 1'b1, 32'h7777_7777, 6'd0);
        check_status("rm_reset", 1'b0, 1'b0, 1'b0, 7'd0);
        do_cycle(1'b1, 1'b0, 1'b1, 32'h7777_7777, 6'd63);
        check_status("rm_idle", 1'b0, 1'b0, 1'b0, 7'd0);
        check("rm.slot63", {32'd0, rd_data}, 64'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rd_idx = 6'(i);
            #1;
            check($sformatf("rm.rd%0d", i), {32'd0, rd_data}, 64'h0);
        end

        // Forwarding: rd_idx=3 while the 4th word is being written
        do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 6'd63);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b0, 1'b1, 32'h8000_0000 + 32'(i), 6'd63);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hCAFE_F00D;
        rd_idx   = 6'd3;
        #1;
`ifdef WORD_DEMUX_BYPASS_EN
        exp_rd = 32'hCAFE_F00D;
`else
        exp_rd = 32'h0000_0000;
`endif
        check("byp.same_cycle", {32'd0, rd_data}, {32'd0, exp_rd});
        @(posedge clk);
        #1;
        check("byp.next_cycle", {32'd0, rd_data}, 64'hCAFE_F00D);
        check("byp.wr_count", {57'd0, wr_count}, 64'd4);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 6'd2);
        check("byp.slot2", {32'd0, rd_data}, 64'h8000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_word_demux_loader
